pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Drives the enable and flush inputs of the PC register, the IF/ID (decode) register and the ID/EX register.
- Resolves load-use hazards, taken-branch redirects and multi-cycle MUL/DIV issue.
- Owns an FSM for the multi-cycle unit handshake with timeout, plus saturating stall/flush performance counters.

---
 rtl/rv_pipe_pkg.sv | 17 +
 rtl/load_use_detect.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the RV32 pipeline control slice.
package rv_pipe_pkg;

  // Default register-address width of the integer register file.
  localparam int REG_AW = 5;

  // Architectural zero register; never a real hazard source.
  localparam logic [REG_AW-1:0] X0_ADDR = '0;

  // Hazard sequencer states.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MDU_START = 2'd1,
    MDU_WAIT  = 2'd2
  } state_e;

endpackage : rv_pipe_pkg

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the decode instruction reads the register that
// the load currently in EX is about to write.
module load_use_detect #(
  parameter int REG_AW = rv_pipe_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_mem_read,
  output logic              o_lu
);
  import rv_pipe_pkg::*;

  logic w_rd_live;
  logic w_hit_rs1;
  logic w_hit_rs2;

  // Compare both decode sources against the load destination; x0 never stalls.
  always_comb begin
    w_rd_live = (i_ex_rd != REG_AW'(X0_ADDR));
    w_hit_rs1 = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    w_hit_rs2 = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    o_lu      = i_ex_mem_read && w_rd_live && (w_hit_rs1 || w_hit_rs2);
  end

endmodule : load_use_detect

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline. Drives PC, IF/ID and
// ID/EX enables/flushes, handles load-use bubbles, branch redirects and the
// multi-cycle MUL/DIV handshake with a timeout abort.
//
// Handshake with the multi-cycle unit: mdu_start is a one-cycle pulse issued
// from MDU_START; the unit answers with a one-cycle mdu_done pulse which is
// only honoured in MDU_WAIT (pulses seen in RUN or MDU_START are dropped).
module pipe_hazard_ctrl #(
  parameter int REG_AW      = rv_pipe_pkg::REG_AW,
  parameter int CNT_W       = 16,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_AW-1:0]    id_rs1,
  input  logic [REG_AW-1:0]    id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_AW-1:0]    ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_branch_taken,
  input  logic                 ex_is_mdu,
  input  logic                 mdu_done,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic                 idex_en,
  output logic                 idex_flush,
  output logic                 mdu_start,
  output logic                 mdu_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output rv_pipe_pkg::state_e  dbg_state
);
  import rv_pipe_pkg::*;

  localparam int TO_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;

  state_e           r_state;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_mdu_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  state_e           w_next_state;
  logic             w_lu;
  logic             w_pc_en;
  logic             w_ifid_en;
  logic             w_ifid_flush;
  logic             w_idex_en;
  logic             w_idex_flush;
  logic             w_mdu_start;
  logic             w_redirect;
  logic             w_timeout;
  logic             w_to_last;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_lu (
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_use_rs1  (id_use_rs1),
    .i_id_use_rs2  (id_use_rs2),
    .i_ex_rd       (ex_rd),
    .i_ex_mem_read (ex_mem_read),
    .o_lu          (w_lu)
  );

  assign w_to_last = (r_to_cnt == TO_W'(MDU_TIMEOUT - 1));

  // Same-cycle control decode from state and pipeline inputs.
  always_comb begin
    w_pc_en      = 1'b0;
    w_ifid_en    = 1'b0;
    w_ifid_flush = 1'b0;
    w_idex_en    = 1'b0;
    w_idex_flush = 1'b0;
    w_mdu_start  = 1'b0;
    w_redirect   = 1'b0;
    w_timeout    = 1'b0;
    w_next_state = r_state;
    if (rst) begin
      // Hold the pipeline frozen with bubbles loaded downstream.
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
      w_next_state = RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (ex_branch_taken) begin
            // Redirect wins: the EX instruction has already resolved.
            w_pc_en      = 1'b1;
            w_ifid_en    = 1'b1;
            w_ifid_flush = 1'b1;
            w_idex_en    = 1'b1;
            w_idex_flush = 1'b1;
            w_redirect   = 1'b1;
          end else if (ex_is_mdu) begin
            w_next_state = MDU_START;
          end else if (w_lu) begin
            // Freeze fetch/decode, push one bubble into EX.
            w_idex_en    = 1'b1;
            w_idex_flush = 1'b1;
          end else begin
            w_pc_en   = 1'b1;
            w_ifid_en = 1'b1;
            w_idex_en = 1'b1;
          end
        end
        MDU_START: begin
          w_mdu_start  = 1'b1;
          w_next_state = MDU_WAIT;
        end
        MDU_WAIT: begin
          if (mdu_done) begin
            w_pc_en      = 1'b1;
            w_ifid_en    = 1'b1;
            w_idex_en    = 1'b1;
            w_next_state = RUN;
          end else if (w_to_last) begin
            // Abort: let the pipeline move on, squash what enters EX.
            w_pc_en      = 1'b1;
            w_ifid_en    = 1'b1;
            w_idex_en    = 1'b1;
            w_idex_flush = 1'b1;
            w_timeout    = 1'b1;
            w_next_state = RUN;
          end
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  // State, timeout counter, sticky error and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_to_cnt    <= '0;
      r_mdu_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == MDU_WAIT && !mdu_done && !w_to_last) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
      if (w_timeout) begin
        r_mdu_err <= 1'b1;
      end
      if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_redirect && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign pc_en      = w_pc_en;
  assign ifid_en    = w_ifid_en;
  assign ifid_flush = w_ifid_flush;
  assign idex_en    = w_idex_en;
  assign idex_flush = w_idex_flush;
  assign mdu_start  = w_mdu_start;
  assign mdu_err    = r_mdu_err;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;
  assign dbg_state  = r_state;

endmodule : pipe_hazard_ctrl
